// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address-mux select codes, exception cause bits,
// vector byte addresses and the exception priority encoder.
package cpu_pkg;

  localparam logic [2:0] SEL_PC      = 3'b000;
  localparam logic [2:0] SEL_ALU     = 3'b001;
  localparam logic [2:0] SEL_EXT16   = 3'b010;
  localparam logic [2:0] SEL_ALUOUT  = 3'b011;
  localparam logic [2:0] SEL_VEC_OPC = 3'b100;
  localparam logic [2:0] SEL_VEC_OVF = 3'b101;
  localparam logic [2:0] SEL_VEC_DIV = 3'b110;
  localparam logic [2:0] SEL_EXT25   = 3'b111;

  localparam int EXC_OPC = 0;
  localparam int EXC_OVF = 1;
  localparam int EXC_DIV = 2;

  localparam logic [7:0] VEC_OPC_ADDR = 8'd253;
  localparam logic [7:0] VEC_OVF_ADDR = 8'd254;
  localparam logic [7:0] VEC_DIV_ADDR = 8'd255;

  // Invalid opcode beats overflow beats divide-by-zero.
  function automatic logic [2:0] exc_vec_sel(input logic [2:0] req);
    logic [2:0] sel;
    sel = SEL_PC;
    if (req[EXC_OPC])      sel = SEL_VEC_OPC;
    else if (req[EXC_OVF]) sel = SEL_VEC_OVF;
    else if (req[EXC_DIV]) sel = SEL_VEC_DIV;
    return sel;
  endfunction

endpackage

// File: rtl/exc_vector_fetch.sv
// Exception-vector fetch sequencer: saves EPC, selects the vector byte,
// waits out memory latency and loads PC with the zero-extended handler byte.
module exc_vector_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = 1,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  exc_req,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  mem_addr_sel,
  output logic        mem_wr,
  output logic [31:0] epc_out,
  output logic        epc_load,
  output logic [31:0] pc_out,
  output logic        pc_load,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SAVE = 3'd1,
    ST_WAIT = 3'd2,
    ST_LOAD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  state_t      state, state_next;
  logic [2:0]  wait_cnt, wait_cnt_next;
  logic [2:0]  vec_sel, vec_sel_next;
  logic        start;

  logic [2:0]  sel_d;
  logic        epc_load_d, pc_load_d, busy_d, done_d;
  logic [31:0] epc_d, pc_d;

  // Only the handler byte matters; the rest of the read word is ignored.
  logic        unused_data;
  assign unused_data = ^mem_data_in[31:8];

  assign mem_wr = 1'b0;
  assign start  = (state == ST_IDLE) && (exc_req != 3'b000);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
      vec_sel  <= SEL_PC;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      vec_sel  <= vec_sel_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = 3'd0;
    case (state)
      ST_IDLE: if (start) state_next = ST_SAVE;
      ST_SAVE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_next = ST_LOAD;
        else                       wait_cnt_next = wait_cnt + 3'd1;
      end
      ST_LOAD: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered
  // in the same cycle the state is entered.
  always_comb begin
    vec_sel_next = start ? exc_vec_sel(exc_req) : vec_sel;
    sel_d        = SEL_PC;
    if (state_next == ST_SAVE || state_next == ST_WAIT || state_next == ST_LOAD)
      sel_d = vec_sel_next;
    busy_d     = (state_next != ST_IDLE);
    epc_load_d = (state_next == ST_SAVE);
    pc_load_d  = (state_next == ST_LOAD);
    done_d     = (state_next == ST_DONE);
    epc_d      = start ? (pc_in - EPC_OFFSET) : epc_out;
    pc_d       = pc_out;
    if (state == ST_WAIT && state_next == ST_LOAD)
      pc_d = {24'b0, mem_data_in[7:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_sel <= SEL_PC;
      epc_out      <= 32'd0;
      epc_load     <= 1'b0;
      pc_out       <= 32'd0;
      pc_load      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      mem_addr_sel <= sel_d;
      epc_out      <= epc_d;
      epc_load     <= epc_load_d;
      pc_out       <= pc_d;
      pc_load      <= pc_load_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_exc_vector_fetch.sv
// Bench for exc_vector_fetch: two instances (MEM_WAIT=1 and MEM_WAIT=3),
// directed requests feed an expected queue that per-instance monitors drain.
module tb_exc_vector_fetch;

  logic clk;
  logic reset;

  logic [2:0]  req0, req1;
  logic [31:0] pcin0, pcin1, mem0, mem1;
  logic [2:0]  sel0, sel1;
  logic        wr0, wr1, el0, el1, pl0, pl1, busy0, busy1, done0, done1;
  logic [31:0] epc0, epc1, pco0, pco1;

  // Entry: {id, sel, epc, handler pc}
  logic [67:0] exp_q[$];
  int          iss_q[$];
  int          cyc;
  int          n_cmp;
  int          n_fail;

  exc_vector_fetch #(.MEM_WAIT(1), .EPC_OFFSET(32'd4)) dut0 (
    .clk(clk), .reset(reset), .exc_req(req0), .pc_in(pcin0), .mem_data_in(mem0),
    .mem_addr_sel(sel0), .mem_wr(wr0), .epc_out(epc0), .epc_load(el0),
    .pc_out(pco0), .pc_load(pl0), .busy(busy0), .done(done0)
  );

  exc_vector_fetch #(.MEM_WAIT(3), .EPC_OFFSET(32'd4)) dut1 (
    .clk(clk), .reset(reset), .exc_req(req1), .pc_in(pcin1), .mem_data_in(mem1),
    .mem_addr_sel(sel1), .mem_wr(wr1), .epc_out(epc1), .epc_load(el1),
    .pc_out(pco1), .pc_load(pl1), .busy(busy1), .done(done1)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor step for one instance; lat is measured from the issue cycle.
  task automatic mon(input int id, input int mw, input logic [2:0] sel, input logic wr,
                     input logic [31:0] epc, input logic el, input logic [31:0] pc,
                     input logic pl, input logic b, input logic d);
    int lat;
    chk($sformatf("strobe_overlap%0d", id), {63'd0, el & pl}, 64'd0);
    if (el | pl | d) begin
      chk($sformatf("mem_wr%0d", id), {63'd0, wr}, 64'd0);
      if (exp_q.size() == 0 || exp_q[0][67] != id[0]) begin
        chk($sformatf("unexpected_out%0d", id), {61'd0, el, pl, d}, 64'd0);
      end else begin
        lat = cyc - iss_q[0];
        if (el) begin
          chk($sformatf("epc%0d", id), {32'd0, epc}, {32'd0, exp_q[0][63:32]});
          chk($sformatf("sel_save%0d", id), {61'd0, sel}, {61'd0, exp_q[0][66:64]});
          chk($sformatf("busy_save%0d", id), {63'd0, b}, 64'd1);
          chk($sformatf("epc_load_lat%0d", id), 64'(lat), 64'd1);
        end
        if (pl) begin
          chk($sformatf("pc_out%0d", id), {32'd0, pc}, {32'd0, exp_q[0][31:0]});
          chk($sformatf("sel_load%0d", id), {61'd0, sel}, {61'd0, exp_q[0][66:64]});
          chk($sformatf("pc_load_lat%0d", id), 64'(lat), 64'(mw + 2));
        end
        if (d) begin
          chk($sformatf("sel_done%0d", id), {61'd0, sel}, 64'd0);
          chk($sformatf("busy_done%0d", id), {63'd0, b}, 64'd1);
          chk($sformatf("done_lat%0d", id), 64'(lat), 64'(mw + 3));
          void'(exp_q.pop_front());
          void'(iss_q.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) if (!reset) mon(0, 1, sel0, wr0, epc0, el0, pco0, pl0, busy0, done0);
  always @(negedge clk) if (!reset) mon(1, 3, sel1, wr1, epc1, el1, pco1, pl1, busy1, done1);

  // Driver tasks
  task automatic drive_req(input int id, input logic [2:0] r);
    if (id == 0) req0 = r; else req1 = r;
  endtask

  task automatic issue(input int id, input logic [2:0] r, input logic [31:0] pc,
                       input logic [31:0] mem, input logic [2:0] e_sel,
                       input logic [31:0] e_epc, input logic [31:0] e_pc, input bit hold);
    @(negedge clk);
    if (id == 0) begin pcin0 = pc; mem0 = mem; end
    else         begin pcin1 = pc; mem1 = mem; end
    drive_req(id, r);
    exp_q.push_back({id[0], e_sel, e_epc, e_pc});
    iss_q.push_back(cyc);
    if (!hold) begin
      @(negedge clk);
      drive_req(id, 3'b000);
    end
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      iss_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_zero(input string tag, input logic [2:0] sel, input logic wr,
                            input logic [31:0] epc, input logic el, input logic [31:0] pc,
                            input logic pl, input logic b, input logic d);
    chk({tag, "_sel"}, {61'd0, sel}, 64'd0);
    chk({tag, "_mem_wr"}, {63'd0, wr}, 64'd0);
    chk({tag, "_epc"}, {32'd0, epc}, 64'd0);
    chk({tag, "_epc_load"}, {63'd0, el}, 64'd0);
    chk({tag, "_pc_out"}, {32'd0, pc}, 64'd0);
    chk({tag, "_pc_load"}, {63'd0, pl}, 64'd0);
    chk({tag, "_busy"}, {63'd0, b}, 64'd0);
    chk({tag, "_done"}, {63'd0, d}, 64'd0);
  endtask

  initial begin
    int c0;
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    req0 = 3'b000; req1 = 3'b000;
    pcin0 = 32'h0; pcin1 = 32'h0; mem0 = 32'h0; mem1 = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero("rst0", sel0, wr0, epc0, el0, pco0, pl0, busy0, done0);
    check_zero("rst1", sel1, wr1, epc1, el1, pco1, pl1, busy1, done1);

    // Overflow, MEM_WAIT=1
    issue(0, 3'b010, 32'h0000_0040, 32'h0000_008C, 3'b101, 32'h0000_003C, 32'h0000_008C, 0);
    wait_drain(20);
    // All three set: opcode wins, upper data bits ignored
    issue(0, 3'b111, 32'h0000_1000, 32'hFFFF_FF20, 3'b100, 32'h0000_0FFC, 32'h0000_0020, 0);
    wait_drain(20);
    // Overflow beats div0
    issue(0, 3'b110, 32'h0000_0030, 32'h1234_005A, 3'b101, 32'h0000_002C, 32'h0000_005A, 0);
    wait_drain(20);
    // pc_in = 0 wraps
    issue(0, 3'b100, 32'h0000_0000, 32'h0000_00AB, 3'b110, 32'hFFFF_FFFC, 32'h0000_00AB, 0);
    wait_drain(20);

    // MEM_WAIT=3: pc_in and exc_req disturbed during WAIT are ignored
    issue(1, 3'b010, 32'h0000_0100, 32'h0000_0044, 3'b101, 32'h0000_00FC, 32'h0000_0044, 0);
    @(negedge clk);
    pcin1 = 32'h0000_0999;
    req1 = 3'b100;
    @(negedge clk);
    req1 = 3'b000;
    wait_drain(30);

    // Reset during WAIT aborts the sequence
    issue(1, 3'b001, 32'h0000_0200, 32'h0000_0011, 3'b100, 32'h0000_01FC, 32'h0000_0011, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("wrst1", sel1, wr1, epc1, el1, pco1, pl1, busy1, done1);
    for (int i = 0; i < 6; i++) begin
      chk("no_pc_load_after_rst", {63'd0, pl1}, 64'd0);
      chk("no_done_after_rst", {63'd0, done1}, 64'd0);
      @(negedge clk);
    end
    exp_q.delete();
    iss_q.delete();
    // A later request runs a full normal sequence
    issue(1, 3'b100, 32'h0000_0080, 32'h1234_5677, 3'b110, 32'h0000_007C, 32'h0000_0077, 0);
    wait_drain(30);

    // Held request: back-to-back sequences one IDLE cycle apart
    issue(0, 3'b001, 32'h0000_2000, 32'h0000_00FD, 3'b100, 32'h0000_1FFC, 32'h0000_00FD, 1);
    c0 = iss_q[$];
    exp_q.push_back({1'b0, 3'b100, 32'h0000_1FFC, 32'h0000_00FD});
    iss_q.push_back(c0 + 5);
    repeat (6) @(negedge clk);
    req0 = 3'b000;
    wait_drain(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
